// File: rtl/mfcc_mel_filter_accum_pkg.sv
// Shared constants for the mel filterbank stage: frame geometry, widths and coefficient word layout.
package mfcc_mel_filter_accum_pkg;

   localparam int unsigned MEL_NBINS  = 257;
   localparam int unsigned MEL_ADDR_W = 9;
   localparam int unsigned MEL_NFILT  = 23;
   localparam int unsigned MEL_PW     = 32;
   localparam int unsigned MEL_WW     = 12;
   localparam int unsigned MEL_ACC_W  = 48;
   localparam int unsigned MEL_IDX_W  = 5;

   localparam logic [MEL_IDX_W-1:0] FILT_NONE = 5'h1F;

   // Coefficient ROM word: filter index above the Q0.WW weight
   localparam int unsigned COEF_W_LSB   = 0;
   localparam int unsigned COEF_IDX_LSB = MEL_WW;

   typedef struct packed {
      logic [MEL_IDX_W-1:0] filt_idx;
      logic [MEL_WW-1:0]    w;
   } coef_t;

endpackage

// File: rtl/mfcc_mel_filter_accum_mac.sv
// Weight split, lower/upper products, product register and saturating adders for the two target filters.
module mfcc_mel_filter_accum_mac
   import mfcc_mel_filter_accum_pkg::*;
#(
   parameter int unsigned PW    = MEL_PW,
   parameter int unsigned WW    = MEL_WW,
   parameter int unsigned ACC_W = MEL_ACC_W,
   parameter int unsigned NFILT = MEL_NFILT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid,
   input  logic [PW-1:0]              p,
   input  logic [MEL_IDX_W+WW-1:0]    coef,
   input  logic [ACC_W-1:0]           acc_lo,
   input  logic [ACC_W-1:0]           acc_up,
   output logic                       lo_en,
   output logic                       up_en,
   output logic [MEL_IDX_W-1:0]       lo_idx,
   output logic [MEL_IDX_W-1:0]       up_idx,
   output logic [ACC_W-1:0]           sum_lo_c,
   output logic [ACC_W-1:0]           sum_up_c
);

   localparam int unsigned PRW = PW + WW;

   logic [MEL_IDX_W-1:0] idx_c;
   logic [WW-1:0]        w_c;
   logic [WW:0]          wu_c;
   logic [PRW-1:0]       prod_lo_c, prod_up_c;
   logic [PRW-1:0]       lo_prod, up_prod;
   logic                 lo_en_c, up_en_c;

   assign idx_c = coef[COEF_IDX_LSB +: MEL_IDX_W];
   assign w_c   = coef[COEF_W_LSB +: WW];
   // Upper weight is 2**WW - w, so a zero weight sends the full bin upward
   assign wu_c      = {1'b1, {WW{1'b0}}} - {1'b0, w_c};
   assign prod_lo_c = PRW'(p) * PRW'(w_c);
   assign prod_up_c = PRW'(p) * PRW'(wu_c);

   // Out-of-range indices (including FILT_NONE) drop the contribution; the last filter has no upper neighbour
   assign lo_en_c = valid && (idx_c < MEL_IDX_W'(NFILT));
   assign up_en_c = valid && (idx_c < MEL_IDX_W'(NFILT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_en   <= 1'b0;
         up_en   <= 1'b0;
         lo_idx  <= '0;
         up_idx  <= '0;
         lo_prod <= '0;
         up_prod <= '0;
      end else begin
         lo_en   <= lo_en_c;
         up_en   <= up_en_c;
         lo_idx  <= idx_c;
         up_idx  <= idx_c + MEL_IDX_W'(1);
         lo_prod <= prod_lo_c;
         up_prod <= prod_up_c;
      end
   end

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [PRW-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W+1)'(b);
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   assign sum_lo_c = sat_add(acc_lo, lo_prod);
   assign sum_up_c = sat_add(acc_up, up_prod);

endmodule

// File: rtl/mfcc_mel_filter_accum.sv
// Mel filterbank stage: accumulates weighted power bins into NFILT filters per frame, then streams the energies out.
module mfcc_mel_filter_accum
   import mfcc_mel_filter_accum_pkg::*;
#(
   parameter int unsigned NBINS      = MEL_NBINS,
   parameter int unsigned ADDR_WIDTH = MEL_ADDR_W,
   parameter int unsigned NFILT      = MEL_NFILT,
   parameter int unsigned PW         = MEL_PW,
   parameter int unsigned WW         = MEL_WW,
   parameter int unsigned ACC_W      = MEL_ACC_W,
   parameter int unsigned ROM_LAT    = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PW-1:0]               in_data,
   input  logic                        in_last,
   output logic [ADDR_WIDTH-1:0]       coef_addr,
   input  logic [MEL_IDX_W+WW-1:0]     coef_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_W-WW-1:0]         out_data,
   output logic [MEL_IDX_W-1:0]        out_idx,
   output logic                        out_last,
   output logic                        frame_err
);

   localparam int unsigned OW = ACC_W - WW;
   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;

   logic [1:0]            state, state_n;
   logic [ADDR_WIDTH-1:0] bin_cnt, bin_cnt_n;
   logic [MEL_IDX_W-1:0]  idx_n;
   logic                  accept_c, frame_end_c, out_hs_c, flush_done_c;
   logic                  mac_valid_c;
   logic [PW-1:0]         mac_p_c;

   logic [ACC_W-1:0]      acc [NFILT];
   logic [ACC_W-1:0]      acc_lo_c, acc_up_c, sum_lo_c, sum_up_c;
   logic [OW-1:0]         out_sel_c;
   logic                  lo_en, up_en;
   logic [MEL_IDX_W-1:0]  lo_idx, up_idx;

   assign accept_c    = in_valid & in_ready;
   assign out_hs_c    = out_valid & out_ready;
   assign frame_end_c = accept_c & (in_last | (bin_cnt == ADDR_WIDTH'(NBINS - 1)));
   assign coef_addr   = bin_cnt;

   // Align the power sample with the ROM word; a registered ROM needs the sample held one stage
   if (ROM_LAT == 0) begin : g_rom_comb
      assign mac_valid_c  = accept_c;
      assign mac_p_c      = in_data;
      assign flush_done_c = 1'b1;
   end else begin : g_rom_reg
      logic          al_valid;
      logic [PW-1:0] al_data;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            al_valid <= 1'b0;
            al_data  <= '0;
         end else begin
            al_valid <= accept_c;
            if (accept_c) al_data <= in_data;
         end
      end
      assign mac_valid_c  = al_valid;
      assign mac_p_c      = al_data;
      assign flush_done_c = !al_valid;
   end

   mfcc_mel_filter_accum_mac #(
      .PW    (PW),
      .WW    (WW),
      .ACC_W (ACC_W),
      .NFILT (NFILT)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (mac_valid_c),
      .p        (mac_p_c),
      .coef     (coef_data),
      .acc_lo   (acc_lo_c),
      .acc_up   (acc_up_c),
      .lo_en    (lo_en),
      .up_en    (up_en),
      .lo_idx   (lo_idx),
      .up_idx   (up_idx),
      .sum_lo_c (sum_lo_c),
      .sum_up_c (sum_up_c)
   );

   always_comb begin
      acc_lo_c  = '0;
      acc_up_c  = '0;
      out_sel_c = '0;
      for (int i = 0; i < NFILT; i++) begin
         if (lo_idx == MEL_IDX_W'(i))  acc_lo_c  = acc[i];
         if (up_idx == MEL_IDX_W'(i))  acc_up_c  = acc[i];
         if (out_idx == MEL_IDX_W'(i)) out_sel_c = acc[i][ACC_W-1:WW];
      end
   end

   assign out_data = out_valid ? out_sel_c : '0;

   // Lower and upper targets are always distinct; the pipeline is empty whenever outputs are draining
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NFILT; i++) acc[i] <= '0;
      end else begin
         for (int i = 0; i < NFILT; i++) begin
            if (lo_en && lo_idx == MEL_IDX_W'(i))         acc[i] <= sum_lo_c;
            else if (up_en && up_idx == MEL_IDX_W'(i))    acc[i] <= sum_up_c;
            else if (out_hs_c && out_idx == MEL_IDX_W'(i)) acc[i] <= '0;
         end
      end
   end

   always_comb begin
      state_n   = state;
      bin_cnt_n = bin_cnt;
      idx_n     = out_idx;
      case (state)
         ST_ACCUM: begin
            if (accept_c) begin
               bin_cnt_n = bin_cnt + ADDR_WIDTH'(1);
               if (frame_end_c) begin
                  state_n   = ST_FLUSH;
                  bin_cnt_n = '0;
               end
            end
         end
         ST_FLUSH: begin
            if (flush_done_c) state_n = ST_OUT;
         end
         ST_OUT: begin
            if (out_hs_c) begin
               if (out_last) begin
                  state_n = ST_ACCUM;
                  idx_n   = '0;
               end else begin
                  idx_n = out_idx + MEL_IDX_W'(1);
               end
            end
         end
         default: state_n = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ACCUM;
         bin_cnt   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bin_cnt   <= bin_cnt_n;
         in_ready  <= (state_n == ST_ACCUM);
         out_valid <= (state_n == ST_OUT);
         out_idx   <= idx_n;
         out_last  <= (state_n == ST_OUT) && (idx_n == MEL_IDX_W'(NFILT - 1));
         frame_err <= accept_c && (in_last != (bin_cnt == ADDR_WIDTH'(NBINS - 1)));
      end
   end

endmodule

// File: tb/tb_mfcc_mel_filter_accum.sv
// Randomized bench for the mel filterbank stage; two instances cover combinational and registered ROM timing.
module tb_mfcc_mel_filter_accum;
   import mfcc_mel_filter_accum_pkg::*;

   localparam longint unsigned ACC_MAX = (64'd1 << MEL_ACC_W) - 64'd1;

   logic clk, rst_n;
   logic in_valid_0, in_valid_1, in_ready_0, in_ready_1, in_last_0, in_last_1;
   logic out_valid_0, out_valid_1, out_ready_0, out_ready_1, out_last_0, out_last_1;
   logic frame_err_0, frame_err_1;
   logic [31:0] in_data_0, in_data_1;
   logic [8:0]  coef_addr_0, coef_addr_1;
   logic [16:0] coef_data_0, coef_data_1;
   logic [35:0] out_data_0, out_data_1;
   logic [4:0]  out_idx_0, out_idx_1;

   bit          sel;
   logic        d_valid, d_last, d_ordy;
   logic [31:0] d_data;
   logic        s_in_ready, s_out_valid, s_out_last, s_frame_err;
   logic [35:0] s_out_data;
   logic [4:0]  s_out_idx;
   logic [8:0]  s_coef_addr;

   logic [16:0]     coef_rom [MEL_NBINS];
   logic [31:0]     pdata    [MEL_NBINS];
   longint unsigned exp_out  [MEL_NFILT];

   int cyc_n  = 0;
   int checks = 0;
   int errors = 0;

   mfcc_mel_filter_accum #(.ROM_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_0), .in_ready(in_ready_0), .in_data(in_data_0),
      .in_last(in_last_0), .coef_addr(coef_addr_0), .coef_data(coef_data_0), .out_valid(out_valid_0),
      .out_ready(out_ready_0), .out_data(out_data_0), .out_idx(out_idx_0), .out_last(out_last_0),
      .frame_err(frame_err_0));

   mfcc_mel_filter_accum #(.ROM_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
      .in_last(in_last_1), .coef_addr(coef_addr_1), .coef_data(coef_data_1), .out_valid(out_valid_1),
      .out_ready(out_ready_1), .out_data(out_data_1), .out_idx(out_idx_1), .out_last(out_last_1),
      .frame_err(frame_err_1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // ROM models: asynchronous read for instance 0, output-registered for instance 1
   assign coef_data_0 = coef_rom[int'(coef_addr_0)];
   always @(posedge clk) coef_data_1 <= coef_rom[int'(coef_addr_1)];

   always_comb begin
      in_valid_0  = d_valid & !sel;
      in_valid_1  = d_valid & sel;
      in_last_0   = d_last;
      in_last_1   = d_last;
      in_data_0   = d_data;
      in_data_1   = d_data;
      out_ready_0 = d_ordy & !sel;
      out_ready_1 = d_ordy & sel;
      s_in_ready  = sel ? in_ready_1  : in_ready_0;
      s_out_valid = sel ? out_valid_1 : out_valid_0;
      s_out_last  = sel ? out_last_1  : out_last_0;
      s_frame_err = sel ? frame_err_1 : frame_err_0;
      s_out_data  = sel ? out_data_1  : out_data_0;
      s_out_idx   = sel ? out_idx_1   : out_idx_0;
      s_coef_addr = sel ? coef_addr_1 : coef_addr_0;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (dut%0d t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   function automatic logic [16:0] cw(input int idx, input int w);
      return {5'(idx), 12'(w)};
   endfunction

   // Reference: sum every accepted bin's triangular split, then clamp and keep the integer part
   function automatic void build_model(input int nb);
      longint unsigned e [MEL_NFILT];
      longint unsigned p, w, idx;
      for (int f = 0; f < MEL_NFILT; f++) e[f] = 0;
      for (int b = 0; b < nb; b++) begin
         idx = longint'(coef_rom[b][16:12]);
         w   = longint'(coef_rom[b][11:0]);
         p   = longint'(pdata[b]);
         if (idx < MEL_NFILT)     e[idx]     += p * w;
         if (idx < MEL_NFILT - 1) e[idx + 1] += p * (4096 - w);
      end
      for (int f = 0; f < MEL_NFILT; f++) exp_out[f] = ((e[f] > ACC_MAX) ? ACC_MAX : e[f]) >> MEL_WW;
   endfunction

   task automatic set_none();
      for (int b = 0; b < MEL_NBINS; b++) begin
         coef_rom[b] = {FILT_NONE, 12'(0)};
         pdata[b]    = $urandom;
      end
   endtask

   task automatic set_scen1();
      set_none();
      coef_rom[10] = cw(3, 2048);
      pdata[10]    = 32'd100;
   endtask

   task automatic set_random();
      int r;
      for (int b = 0; b < MEL_NBINS; b++) begin
         r = $urandom_range(0, 9);
         if (r < 2)       coef_rom[b] = {FILT_NONE, 12'($urandom_range(0, 4095))};
         else if (r == 2) coef_rom[b] = cw($urandom_range(23, 30), $urandom_range(0, 4095));
         else             coef_rom[b] = cw($urandom_range(0, 22), $urandom_range(0, 4095));
         pdata[b] = $urandom;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  64'(s_in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(s_out_valid), 64'd0);
      check({tag, "_out_data"},  64'(s_out_data), 64'd0);
      check({tag, "_out_idx"},   64'(s_out_idx), 64'd0);
      check({tag, "_out_last"},  64'(s_out_last), 64'd0);
      check({tag, "_frame_err"}, 64'(s_frame_err), 64'd0);
      check({tag, "_coef_addr"}, 64'(s_coef_addr), 64'd0);
   endtask

   task automatic run_frame(input bit d, input int nb, input bit send_last, input int rdy_pct);
      int b = 0, k = 0, guard = 0, t_last = 0, first = -1, errs = 0;
      bit ready_leak = 1'b0;
      bit exp_err;
      sel = d;
      build_model(nb);
      exp_err = send_last ? (nb != MEL_NBINS) : (nb == MEL_NBINS);
      while (b < nb && guard < 4000) begin
         @(negedge clk);
         guard++;
         if (s_frame_err) errs++;
         d_valid = ($urandom_range(0, 3) != 0);
         d_data  = pdata[b];
         d_last  = send_last && (b == nb - 1);
         if (d_valid && s_in_ready) begin
            check("coef_addr", 64'(s_coef_addr), 64'(b));
            if (b == nb - 1) t_last = cyc_n;
            b++;
         end
      end
      check("bins_accepted", 64'(b), 64'(nb));
      guard = 0;
      while (k < MEL_NFILT && guard < 3000) begin
         @(negedge clk);
         guard++;
         d_valid = 1'b0;
         d_last  = 1'b0;
         if (s_frame_err) errs++;
         if (s_in_ready) ready_leak = 1'b1;
         d_ordy = ($urandom_range(0, 99) < rdy_pct);
         if (s_out_valid) begin
            if (first < 0) first = cyc_n;
            check("out_data", 64'(s_out_data), exp_out[k]);
            check("out_idx",  64'(s_out_idx), 64'(k));
            check("out_last", 64'(s_out_last), 64'(k == MEL_NFILT - 1));
            if (d_ordy) k++;
         end
      end
      @(negedge clk);
      d_ordy = 1'b0;
      check("out_count",   64'(k), 64'(MEL_NFILT));
      check("latency",     64'(first - t_last), 64'(2 + int'(d)));
      check("frame_err",   64'(errs), 64'(exp_err));
      check("ready_low",   64'(ready_leak), 64'd0);
      check("ready_after", 64'(s_in_ready), 64'd1);
      check("valid_after", 64'(s_out_valid), 64'd0);
   endtask

   task automatic abort_frame(input int n_acc);
      int b = 0, guard = 0;
      sel = 1'b0;
      while (b < n_acc && guard < 1000) begin
         @(negedge clk);
         guard++;
         d_valid = 1'b1;
         d_data  = pdata[b];
         d_last  = 1'b0;
         if (s_in_ready) b++;
      end
      @(negedge clk);
      rst_n   = 1'b0;
      d_valid = 1'b0;
      #1;
      check_idle("abort_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("abort_post");
   endtask

   initial begin
      rst_n   = 1'b0;
      sel     = 1'b0;
      d_valid = 1'b0;
      d_last  = 1'b0;
      d_ordy  = 1'b0;
      d_data  = '0;
      set_none();
      repeat (3) @(negedge clk);
      check_idle("reset0");
      sel = 1'b1;
      #1;
      check_idle("reset1");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      set_scen1();
      run_frame(1'b0, MEL_NBINS, 1'b1, 100);
      check("scen1_idx3", exp_out[3], 64'd50);
      run_frame(1'b1, MEL_NBINS, 1'b1, 100);

      set_none();
      coef_rom[5] = cw(22, 1024);
      pdata[5]    = 32'd4096;
      run_frame(1'b0, MEL_NBINS, 1'b1, 80);

      for (int b = 0; b < MEL_NBINS; b++) begin
         coef_rom[b] = cw(0, 4095);
         pdata[b]    = 32'hFFFF_FFFF;
      end
      run_frame(1'b1, MEL_NBINS, 1'b1, 70);
      run_frame(1'b0, MEL_NBINS, 1'b1, 50);

      set_random();
      run_frame(1'b0, MEL_NBINS, 1'b1, 50);
      set_random();
      run_frame(1'b1, MEL_NBINS, 1'b1, 50);

      set_scen1();
      run_frame(1'b0, 101, 1'b1, 60);
      set_random();
      run_frame(1'b1, MEL_NBINS, 1'b0, 60);

      set_scen1();
      abort_frame(50);
      run_frame(1'b0, MEL_NBINS, 1'b1, 100);

      for (int n = 0; n < 3; n++) begin
         set_random();
         run_frame(1'(n & 1), $urandom_range(1, 256), 1'b1, 40);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
